// File: rtl/pixel_plotter_if.sv
// Pixel input stream (valid/ready) and framebuffer write port of the pixel plotter.
// The plotter takes the slave side; the rasteriser/framebuffer side takes master.
interface pixel_plotter_if #(
  parameter int ADDR_W  = 15,
  parameter int COLOR_W = 3
);
  logic               pix_valid;
  logic               pix_ready;
  logic [7:0]         pix_x;
  logic [7:0]         pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               fb_busy;

  modport master (
    output pix_valid, pix_x, pix_y, pix_color, fb_busy,
    input  pix_ready, fb_we, fb_addr, fb_data
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_color, fb_busy,
    output pix_ready, fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/pixel_plotter.sv
// Pixel plotter: FIFO -> S1 (clip, address) -> S2 (framebuffer write registers).
// Off-screen pixels are dropped and counted; FB_BUSY stalls S2 and backs up into the FIFO.
module pixel_plotter #(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int ADDR_W     = 15,
  parameter int COLOR_W    = 3
) (
  input  logic            aclk,
  input  logic            rst,
  pixel_plotter_if.slave  bus,
  output logic [15:0]     clip_cnt,
  output logic            idle
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 16 + COLOR_W;

  logic [EW-1:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW:0]        count;
  logic               fifo_full, fifo_empty, push, pop;

  logic               s1_valid;
  logic [7:0]         s1_x, s1_y;
  logic [COLOR_W-1:0] s1_color;
  logic               s1_clipped, s1_adv, s1_load;
  logic [ADDR_W-1:0]  s1_addr;

  logic               s2_valid, s2_load;
  logic [ADDR_W-1:0]  s2_addr;
  logic [COLOR_W-1:0] s2_data;

  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // Stage advance chain: S2 frees up unless stalled, S1 follows S2, FIFO follows S1.
  assign s2_load = !s2_valid || !bus.fb_busy;
  assign s1_adv  = s1_valid && s2_load;
  assign s1_load = !s1_valid || s1_adv;
  assign push    = bus.pix_valid && !fifo_full;
  assign pop     = !fifo_empty && s1_load;

  assign s1_clipped = ({1'b0, s1_x} >= 9'(SCREEN_W)) || ({1'b0, s1_y} >= 9'(SCREEN_H));
  assign s1_addr    = ADDR_W'(s1_y) * ADDR_W'(SCREEN_W) + ADDR_W'(s1_x);

  assign bus.pix_ready = !fifo_full;
  assign bus.fb_we     = s2_valid;
  assign bus.fb_addr   = s2_addr;
  assign bus.fb_data   = s2_data;
  assign idle          = fifo_empty && !s1_valid && !s2_valid;

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= {bus.pix_color, bus.pix_y, bus.pix_x};
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_color <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_data  <= '0;
      clip_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      if (s1_load) begin
        s1_valid <= !fifo_empty;
        if (!fifo_empty) {s1_color, s1_y, s1_x} <= mem[rd_ptr];
      end

      // A clipped pixel leaves S1 as a bubble in S2.
      if (s2_load) begin
        s2_valid <= s1_valid && !s1_clipped;
        if (s1_valid && !s1_clipped) begin
          s2_addr <= s1_addr;
          s2_data <= s1_color;
        end
      end

      if (s1_adv && s1_clipped && clip_cnt != 16'hFFFF) clip_cnt <= clip_cnt + 1'b1;
    end
  end
endmodule
